// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, read-mode encodings and sizing helper for the FIFO family
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    localparam bit SA_REGISTERED = 1'b0;
    localparam bit SA_FWFT       = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, synchronous write port, asynchronous read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy, threshold flags and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit SHOW_AHEAD = SA_REGISTERED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    read,
    output logic [WIDTH-1:0]        data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] head, dout_q;
    logic             wr_acc, rd_acc;

    assign empty        = count == '0;
    assign full         = count == CW'(DEPTH);
    assign almost_empty = count <= CW'(AE_LEVEL);
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign wr_acc       = write & ~full;
    assign rd_acc       = read & ~empty;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // A new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dout_q    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (rd_acc) dout_q <= head;
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= (write & full) | (overflow & ~err_clr);
            underflow <= (read & empty) | (underflow & ~err_clr);
        end
    end

    assign data_out = SHOW_AHEAD ? (empty ? '0 : head) : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed table and corner sequences for registered and show-ahead FIFOs
module tb_sync_fifo_param;

    logic       clk, reset, write, read, err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out, sa_dout;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic       sa_empty, sa_full, sa_ae, sa_af, sa_ovf, sa_udf;
    logic [3:0] count, sa_count;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .SHOW_AHEAD(1'b0)) dut (
        .clk(clk), .reset(reset), .write(write), .data_in(data_in), .read(read),
        .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .SHOW_AHEAD(1'b1)) dut_sa (
        .clk(clk), .reset(reset), .write(write), .data_in(data_in), .read(read),
        .data_out(sa_dout), .empty(sa_empty), .full(sa_full), .almost_empty(sa_ae),
        .almost_full(sa_af), .count(sa_count), .overflow(sa_ovf),
        .underflow(sa_udf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, w, r, clr;
        logic [7:0] din;
        logic [3:0] cnt;
        logic [3:0] flags;
        logic       ovf, udf;
        logic [7:0] dout, sa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, w, r, clr, input logic [7:0] din,
                               input logic [3:0] cnt, input logic [3:0] flags,
                               input logic ovf, udf, input logic [7:0] dout, sa);
        vec_t t;
        t.rst = rst; t.w = w; t.r = r; t.clr = clr; t.din = din;
        t.cnt = cnt; t.flags = flags; t.ovf = ovf; t.udf = udf; t.dout = dout; t.sa = sa;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_i, w, r, clr, input logic [7:0] d);
        reset = rst_i; write = w; read = r; err_clr = clr; data_in = d;
        @(posedge clk);
        #1;
        reset = 0; write = 0; read = 0; err_clr = 0; data_in = 8'h00;
    endtask

    initial begin
        clk = 0; reset = 0; write = 0; read = 0; err_clr = 0; data_in = 0;
        // flags = {empty, full, almost_empty, almost_full}
        tbl.push_back(v(1,0,0,0,8'h00, 0,4'b1010,0,0,8'h00,8'h00));
        tbl.push_back(v(0,1,0,0,8'h01, 1,4'b0010,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h02, 2,4'b0000,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h03, 3,4'b0000,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h04, 4,4'b0000,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h05, 5,4'b0000,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h06, 6,4'b0000,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h07, 7,4'b0001,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'h08, 8,4'b0101,0,0,8'h00,8'h01));
        tbl.push_back(v(0,1,0,0,8'hFF, 8,4'b0101,1,0,8'h00,8'h01));
        tbl.push_back(v(0,0,1,0,8'h00, 7,4'b0001,1,0,8'h01,8'h02));
        tbl.push_back(v(0,0,1,0,8'h00, 6,4'b0000,1,0,8'h02,8'h03));
        tbl.push_back(v(0,0,1,0,8'h00, 5,4'b0000,1,0,8'h03,8'h04));
        tbl.push_back(v(0,0,1,0,8'h00, 4,4'b0000,1,0,8'h04,8'h05));
        tbl.push_back(v(0,0,1,0,8'h00, 3,4'b0000,1,0,8'h05,8'h06));
        tbl.push_back(v(0,0,1,0,8'h00, 2,4'b0000,1,0,8'h06,8'h07));
        tbl.push_back(v(0,0,1,0,8'h00, 1,4'b0010,1,0,8'h07,8'h08));
        tbl.push_back(v(0,0,1,0,8'h00, 0,4'b1010,1,0,8'h08,8'h00));
        tbl.push_back(v(0,0,1,0,8'h00, 0,4'b1010,1,1,8'h08,8'h00));
        tbl.push_back(v(0,0,0,1,8'h00, 0,4'b1010,0,0,8'h08,8'h00));
        tbl.push_back(v(0,0,1,1,8'h00, 0,4'b1010,0,1,8'h08,8'h00));
        tbl.push_back(v(0,0,0,1,8'h00, 0,4'b1010,0,0,8'h08,8'h00));
        tbl.push_back(v(0,1,0,0,8'h5A, 1,4'b0010,0,0,8'h08,8'h5A));
        tbl.push_back(v(0,0,1,0,8'h00, 0,4'b1010,0,0,8'h5A,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].din);
            chk($sformatf("v%0d count", i), count, tbl[i].cnt);
            chk($sformatf("v%0d flags", i), {empty, full, almost_empty, almost_full}, tbl[i].flags);
            chk($sformatf("v%0d overflow", i), overflow, tbl[i].ovf);
            chk($sformatf("v%0d underflow", i), underflow, tbl[i].udf);
            chk($sformatf("v%0d data_out", i), data_out, tbl[i].dout);
            chk($sformatf("v%0d sa_data_out", i), sa_dout, tbl[i].sa);
        end

        // Steady state at count 4 with pointers wrapping several times
        step(1,0,0,0,8'h00);
        for (int i = 0; i < 4; i++) step(0,1,0,0,8'(8'h10 + i));
        chk("stream fill count", count, 4);
        chk("stream fill head", sa_dout, 8'h10);
        for (int i = 0; i < 20; i++) begin
            step(0,1,1,0,8'(8'h14 + i));
            chk($sformatf("stream%0d count", i), count, 4);
            chk($sformatf("stream%0d data_out", i), data_out, 8'(8'h10 + i));
            chk($sformatf("stream%0d sa head", i), sa_dout, 8'(8'h11 + i));
        end

        // Show-ahead head appears without a read, then clears on pop to empty
        step(1,0,0,0,8'h00);
        step(0,1,0,0,8'hA5);
        chk("sa head after write", sa_dout, 8'hA5);
        chk("reg dout before read", data_out, 8'h00);
        step(0,0,0,0,8'h00);
        chk("sa head idle", sa_dout, 8'hA5);
        step(0,0,1,0,8'h00);
        chk("sa empty after pop", sa_empty, 1);
        chk("sa dout empty", sa_dout, 8'h00);
        chk("reg dout after read", data_out, 8'hA5);

        // Reset with a concurrent write discards everything
        for (int i = 0; i < 5; i++) step(0,1,0,0,8'(8'h60 + i));
        chk("pre-reset count", count, 5);
        step(1,1,0,0,8'h77);
        chk("reset-write count", count, 0);
        chk("reset-write empty", empty, 1);
        step(0,1,0,0,8'h3C);
        chk("post-reset sa head", sa_dout, 8'h3C);
        step(0,0,1,0,8'h00);
        chk("post-reset data_out", data_out, 8'h3C);

        // Simultaneous read+write when full: read wins, write rejected
        step(1,0,0,0,8'h00);
        for (int i = 0; i < 8; i++) step(0,1,0,0,8'(8'h20 + i));
        step(0,1,1,0,8'h99);
        chk("full rw count", count, 7);
        chk("full rw overflow", overflow, 1);
        chk("full rw data_out", data_out, 8'h20);
        for (int i = 1; i < 8; i++) begin
            step(0,0,1,0,8'h00);
            chk($sformatf("drain%0d data_out", i), data_out, 8'(8'h20 + i));
        end
        chk("drain empty", empty, 1);

        // Simultaneous read+write when empty: write wins, read flagged
        step(1,0,0,0,8'h00);
        step(0,1,1,0,8'h42);
        chk("empty rw count", count, 1);
        chk("empty rw underflow", underflow, 1);
        chk("empty rw data_out", data_out, 8'h00);
        chk("empty rw sa head", sa_dout, 8'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO, the next generation of the team's 8×8 FIFO. Generalises data width and depth, adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable show-ahead read mode. Sits between any producer/consumer pair in the same clock domain as a drop-in rate-matching buffer.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- SHOW_AHEAD, 0, 0 = registered read (data after read), 1 = first-word-fall-through
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock domain only
- write  input  1  write request
- data_in  input  WIDTH  write data
- read  input  1  read request
- data_out  output  WIDTH  read data
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_empty  output  1  count ≤ AE_LEVEL
- almost_full  output  1  count ≥ AF_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- overflow  output  1  sticky: write requested while full and not accepted
- underflow  output  1  sticky: read requested while empty
- err_clr  input  1  clears overflow/underflow

## Operation
- Internal: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap naturally DEPTH-1 → 0), count register, storage array DEPTH×WIDTH.
- wr_acc = write & ~full; rd_acc = read & ~empty. Acceptance uses flags from registered count (pre-edge state).
- wr_acc: mem[wr_ptr] ← data_in, wr_ptr+1. rd_acc: rd_ptr+1.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Simultaneous read+write when full: read accepted, write rejected, overflow set. When empty: write accepted, read rejected, underflow set. Otherwise both accepted, count unchanged.
- overflow ← 1 on write & full; underflow ← 1 on read & empty; both held until err_clr or reset. Same-cycle err_clr and new error: error wins (flag remains 1).
- SHOW_AHEAD=0: on rd_acc, data_out ← mem[rd_ptr] at the edge; otherwise holds.
- SHOW_AHEAD=1: data_out = mem[rd_ptr] combinationally when ~empty, 0 when empty; rd_acc pops the head.
- Flags are pure decodes of count; no separate flag registers.
- Storage contents are not reset.

## Timing
- reset dominates write/read/err_clr in the same cycle. After reset edge: count=0, pointers=0, empty=1, full=0, almost_empty=1, almost_full=0 (or 1 if AF_LEVEL=0 – illegal), overflow=0, underflow=0, data_out=0.
- Reset mid-operation discards all contents; first word written afterwards is the first read.
- Write at edge N: count/empty/full update after edge N; word readable from cycle N+1.
- SHOW_AHEAD=0 read latency 1: read accepted at edge N, data_out valid after edge N, held until next rd_acc.
- SHOW_AHEAD=1 read latency 0: head word visible in the cycle after the write that made FIFO non-empty.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package/include fifo_pkg: clog2 function, default WIDTH/DEPTH constants, SHOW_AHEAD mode encodings.
- One sub-module: fifo_mem (DEPTH×WIDTH, one synchronous write port, one asynchronous read port addressed by rd_ptr); top holds pointers, count, flags, output register.

## Test plan
- Reset then idle → empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
- DEPTH=8, write 0x01..0x08 → full=1, count=8, almost_full from count=7; ninth write 0xFF → overflow=1, count stays 8; read all → 0x01..0x08 in order, 0xFF never appears.
- Read while empty → underflow=1, count=0, rd_ptr unchanged; err_clr → underflow=0.
- Fill 4, then 20 cycles simultaneous write/read with incrementing data → count stays 4, outputs in order across pointer wrap.
- SHOW_AHEAD=1: write 0xA5 → next cycle data_out=0xA5 with no read; read → empty=1, data_out=0.
- Fill 5, assert reset with write=1 → count=0, empty=1; next write 0x3C then read → data_out=0x3C.
